tdc_uart_rx: RTL and testbench



---
 rtl/tdc_uart_rx.sv | 183 ++++++++++++++++++
 tb/tb_tdc_uart_rx.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/tdc_uart_rx.sv
// rtl/tdc_uart_rx.sv - UART receiver that assembles NBYTES-byte TDC measurement words
// Optional even-parity bit between data and stop when TDC_UART_PARITY_EN is defined.
module tdc_uart_rx #(
  parameter int CLKS_PER_BIT = 434,
  parameter int NBYTES       = 2,
  parameter int TIMEOUT_BITS = 20
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                rx,
  output logic [7:0]          byte_data,
  output logic                byte_valid,
  output logic [8*NBYTES-1:0] result,
  output logic                result_valid,
  input  logic                result_ready,
  output logic                frame_err,
  output logic                overrun
);
  localparam int CW   = $clog2(CLKS_PER_BIT);
  localparam int IW   = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam int SW   = (NBYTES > 1) ? 8*(NBYTES-1) : 8;
  localparam int TLIM = TIMEOUT_BITS*CLKS_PER_BIT;
  localparam int TW   = $clog2(TLIM + 1);

`ifdef TDC_UART_PARITY_EN
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;
`else
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;
`endif

  state_t               r_state, w_state_nxt;
  logic                 r_rx_meta, r_rx_sync, r_armed;
  logic [CW-1:0]        r_bit_cnt;
  logic [2:0]           r_bit_idx;
  logic [7:0]           r_shift, r_byte_data;
  logic                 r_byte_valid, r_frame_err, r_overrun, r_result_valid;
  logic [IW-1:0]        r_byte_idx;
  logic [SW-1:0]        r_staging;
  logic [8*NBYTES-1:0]  r_result, w_frame;
  logic [TW-1:0]        r_tmo_cnt;
  logic                 w_half_hit, w_full_hit, w_byte_ok, w_frame_err;
`ifdef TDC_UART_PARITY_EN
  logic                 r_par_err;
`endif

  assign w_half_hit = (r_bit_cnt == CW'(CLKS_PER_BIT/2 - 1));
  assign w_full_hit = (r_bit_cnt == CW'(CLKS_PER_BIT - 1));

  always_comb begin
    w_state_nxt = r_state;
    w_byte_ok   = 1'b0;
    w_frame_err = 1'b0;
    case (r_state)
      S_IDLE:   if (r_armed && !r_rx_sync) w_state_nxt = S_START;
      S_START:  if (w_half_hit) w_state_nxt = r_rx_sync ? S_IDLE : S_DATA;
`ifdef TDC_UART_PARITY_EN
      S_DATA:   if (w_full_hit && r_bit_idx == 3'd7) w_state_nxt = S_PARITY;
      S_PARITY: if (w_full_hit) w_state_nxt = S_STOP;
`else
      S_DATA:   if (w_full_hit && r_bit_idx == 3'd7) w_state_nxt = S_STOP;
`endif
      S_STOP: begin
        if (w_full_hit) begin
          w_state_nxt = S_IDLE;
`ifdef TDC_UART_PARITY_EN
          w_frame_err = !r_rx_sync || r_par_err;
`else
          w_frame_err = !r_rx_sync;
`endif
          w_byte_ok   = !w_frame_err;
        end
      end
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_rx_meta    <= 1'b1;
      r_rx_sync    <= 1'b1;
      r_armed      <= 1'b1;
      r_state      <= S_IDLE;
      r_bit_cnt    <= '0;
      r_bit_idx    <= '0;
      r_shift      <= '0;
      r_byte_data  <= '0;
      r_byte_valid <= 1'b0;
      r_frame_err  <= 1'b0;
`ifdef TDC_UART_PARITY_EN
      r_par_err    <= 1'b0;
`endif
    end else begin
      r_rx_meta    <= rx;
      r_rx_sync    <= r_rx_meta;
      r_state      <= w_state_nxt;
      r_byte_valid <= w_byte_ok;
      r_frame_err  <= w_frame_err;
      if (w_byte_ok) r_byte_data <= r_shift;
      // a line stuck low must go high again before the next start bit counts
      if (w_frame_err && !r_rx_sync) r_armed <= 1'b0;
      else if (r_rx_sync)            r_armed <= 1'b1;
      case (r_state)
        S_IDLE: r_bit_cnt <= '0;
        S_START: begin
          r_bit_idx <= '0;
          r_bit_cnt <= w_half_hit ? '0 : r_bit_cnt + CW'(1);
        end
        S_DATA: begin
          if (w_full_hit) begin
            r_bit_cnt <= '0;
            r_shift   <= {r_rx_sync, r_shift[7:1]};
            r_bit_idx <= r_bit_idx + 3'd1;
          end else begin
            r_bit_cnt <= r_bit_cnt + CW'(1);
          end
        end
`ifdef TDC_UART_PARITY_EN
        S_PARITY: begin
          if (w_full_hit) begin
            r_bit_cnt <= '0;
            r_par_err <= r_rx_sync ^ (^r_shift);
          end else begin
            r_bit_cnt <= r_bit_cnt + CW'(1);
          end
        end
`endif
        default: r_bit_cnt <= w_full_hit ? '0 : r_bit_cnt + CW'(1);
      endcase
    end
  end

  if (NBYTES > 1) begin : g_multi
    assign w_frame = {r_byte_data, r_staging};
  end else begin : g_single
    assign w_frame = r_byte_data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_byte_idx     <= '0;
      r_staging      <= '0;
      r_result       <= '0;
      r_result_valid <= 1'b0;
      r_overrun      <= 1'b0;
      r_tmo_cnt      <= '0;
    end else begin
      r_overrun <= 1'b0;
      if (r_result_valid && result_ready) r_result_valid <= 1'b0;
      if (r_byte_valid) begin
        r_tmo_cnt <= '0;
        if (r_byte_idx == IW'(NBYTES-1)) begin
          r_byte_idx <= '0;
          if (!r_result_valid || result_ready) begin
            r_result       <= w_frame;
            r_result_valid <= 1'b1;
          end else begin
            r_overrun <= 1'b1;
          end
        end else begin
          r_staging[8*r_byte_idx +: 8] <= r_byte_data;
          r_byte_idx <= r_byte_idx + IW'(1);
        end
      end else if (w_frame_err) begin
        r_byte_idx <= '0;
      end else if (r_byte_idx != '0 && r_state == S_IDLE) begin
        // inter-byte gap too long: drop the partial frame without a pulse
        if (r_tmo_cnt == TW'(TLIM-1)) begin
          r_byte_idx <= '0;
          r_tmo_cnt  <= '0;
        end else begin
          r_tmo_cnt <= r_tmo_cnt + TW'(1);
        end
      end
    end
  end

  assign byte_data    = r_byte_data;
  assign byte_valid   = r_byte_valid;
  assign result       = r_result;
  assign result_valid = r_result_valid;
  assign frame_err    = r_frame_err;
  assign overrun      = r_overrun;
endmodule

// File: tb/tb_tdc_uart_rx.sv
// tb/tb_tdc_uart_rx.sv - scoreboard bench for tdc_uart_rx (CLKS_PER_BIT=4, NBYTES=2)
// Optional parity step runs when TDC_UART_PARITY_EN is defined.
module tb_tdc_uart_rx;
  localparam int CPB = 4;
  localparam int NB  = 2;
  localparam int TOB = 20;
`ifdef TDC_UART_PARITY_EN
  localparam int LAT = CPB/2 + 10*CPB + 3;
`else
  localparam int LAT = CPB/2 + 9*CPB + 3;
`endif

  logic        clk = 1'b0, reset = 1'b1, rx = 1'b1, result_ready = 1'b1;
  logic [7:0]  byte_data;
  logic        byte_valid, result_valid, frame_err, overrun;
  logic [15:0] result;
  logic        prev_rv = 1'b0;
  int          nchk = 0, npass = 0;
  int          n_ferr = 0, n_ovr = 0, n_bv = 0;
  int          cyc = 0, start_cyc = 0, bv_cyc = 0;
  int          f0, o0, b0, lat;
  logic [7:0]  byte_q[$];
  logic [15:0] res_q[$];

  tdc_uart_rx #(.CLKS_PER_BIT(CPB), .NBYTES(NB), .TIMEOUT_BITS(TOB)) dut (
    .clk(clk), .reset(reset), .rx(rx),
    .byte_data(byte_data), .byte_valid(byte_valid),
    .result(result), .result_valid(result_valid), .result_ready(result_ready),
    .frame_err(frame_err), .overrun(overrun)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchk++;
    assert (obs === exp) npass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic chk_true(input string tag, input logic cond);
    nchk++;
    assert (cond) npass++;
    else $error("FAIL %s: observed 0 expected 1", tag);
  endtask

  task automatic send_bit(input logic v);
    rx = v;
    repeat (CPB) @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] d, input logic stop);
    start_cyc = cyc;
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
`ifdef TDC_UART_PARITY_EN
    send_bit(^d);
`endif
    send_bit(stop);
  endtask

  task automatic idle(input int n);
    rx = 1'b1;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk_outputs_zero(input string tag);
    chk({tag, "_byte_data"}, byte_data, 0);
    chk({tag, "_byte_valid"}, byte_valid, 0);
    chk({tag, "_result"}, result, 0);
    chk({tag, "_result_valid"}, result_valid, 0);
    chk({tag, "_frame_err"}, frame_err, 0);
    chk({tag, "_overrun"}, overrun, 0);
  endtask

  always @(negedge clk) begin
    if (reset) begin
      prev_rv <= 1'b0;
    end else begin
      if (byte_valid) begin
        n_bv   <= n_bv + 1;
        bv_cyc <= cyc;
        chk_true("byte_expected", byte_q.size() != 0);
        if (byte_q.size() != 0) chk("byte_data", byte_data, byte_q.pop_front());
      end
      if (result_valid && !prev_rv) begin
        chk_true("result_expected", res_q.size() != 0);
        if (res_q.size() != 0) chk("result", result, res_q.pop_front());
      end
      if (frame_err) n_ferr <= n_ferr + 1;
      if (overrun)   n_ovr  <= n_ovr + 1;
      prev_rv <= result_valid;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (4) @(posedge clk);
    #1;
    chk_outputs_zero("reset");
    reset = 1'b0;
    idle(3 * CPB);

    // back-to-back bytes assemble little-endian into one frame
    byte_q.push_back(8'h34); byte_q.push_back(8'h12); res_q.push_back(16'h1234);
    send_byte(8'h34, 1'b1);
    send_byte(8'h12, 1'b1);
    idle(3 * CPB);
    chk("t1_result", result, 16'h1234);
    chk("t1_result_valid_consumed", result_valid, 0);
    chk("t1_res_q_empty", res_q.size(), 0);
    chk("t1_frame_err", n_ferr, 0);
    chk("t1_overrun", n_ovr, 0);

    // pending result blocks a second frame, which overruns
    result_ready = 1'b0;
    o0 = n_ovr;
    byte_q.push_back(8'hEF); byte_q.push_back(8'hBE); res_q.push_back(16'hBEEF);
    byte_q.push_back(8'h01); byte_q.push_back(8'h00);
    send_byte(8'hEF, 1'b1); send_byte(8'hBE, 1'b1);
    send_byte(8'h01, 1'b1); send_byte(8'h00, 1'b1);
    idle(3 * CPB);
    chk("t2_result_held", result, 16'hBEEF);
    chk("t2_result_valid_held", result_valid, 1);
    chk("t2_overrun_once", n_ovr - o0, 1);
    result_ready = 1'b1;
    @(posedge clk); #1;
    chk("t2_result_valid_drop", result_valid, 0);
    chk("t2_res_q_empty", res_q.size(), 0);

    // low stop bit: one frame_err, byte dropped, next frame intact
    f0 = n_ferr; b0 = n_bv;
    send_byte(8'hA5, 1'b0);
    idle(2 * CPB);
    chk("t3_frame_err_once", n_ferr - f0, 1);
    chk("t3_no_byte_valid", n_bv - b0, 0);
    byte_q.push_back(8'h11); byte_q.push_back(8'h22); res_q.push_back(16'h2211);
    send_byte(8'h11, 1'b1); send_byte(8'h22, 1'b1);
    idle(3 * CPB);
    chk("t3_result", result, 16'h2211);
    chk("t3_res_q_empty", res_q.size(), 0);

    // short glitch is rejected at the half-bit check
    f0 = n_ferr; b0 = n_bv;
    rx = 1'b0;
    @(posedge clk); #1;
    idle(5 * CPB);
    chk("t4_no_byte_valid", n_bv - b0, 0);
    chk("t4_no_frame_err", n_ferr - f0, 0);

    // lone byte times out; following pair forms the frame
    byte_q.push_back(8'h77);
    send_byte(8'h77, 1'b1);
    idle(21 * CPB);
    lat = bv_cyc - start_cyc;
    chk_true("t5_byte_latency", lat >= LAT - 1 && lat <= LAT + 1);
    byte_q.push_back(8'h55); byte_q.push_back(8'h66); res_q.push_back(16'h6655);
    send_byte(8'h55, 1'b1); send_byte(8'h66, 1'b1);
    idle(3 * CPB);
    chk("t5_result", result, 16'h6655);
    chk("t5_res_q_empty", res_q.size(), 0);

    // reset during bit 4 of the second byte abandons the partial frame
    byte_q.push_back(8'hAA);
    send_byte(8'hAA, 1'b1);
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(i[0]);
    rx = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    rx = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk_outputs_zero("t6_reset");
    reset = 1'b0;
    idle(3 * CPB);
    chk("t6_byte_q_empty", byte_q.size(), 0);
    byte_q.push_back(8'h0F); byte_q.push_back(8'hF0); res_q.push_back(16'hF00F);
    send_byte(8'h0F, 1'b1); send_byte(8'hF0, 1'b1);
    idle(3 * CPB);
    chk("t6_result", result, 16'hF00F);
    chk("t6_res_q_empty", res_q.size(), 0);

`ifdef TDC_UART_PARITY_EN
    // wrong parity on 0x0F: frame_err, no byte, no result
    f0 = n_ferr; b0 = n_bv;
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(i < 4);
    send_bit(1'b1);
    send_bit(1'b1);
    idle(3 * CPB);
    chk("tp_frame_err", n_ferr - f0, 1);
    chk("tp_no_byte_valid", n_bv - b0, 0);
    chk("tp_no_result", result_valid, 0);
`endif

    chk("final_byte_q_empty", byte_q.size(), 0);
    chk("final_res_q_empty", res_q.size(), 0);
    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end
endmodule
